// File: rtl/sirv_aon_regvec_ctrl_pkg.sv
// Shared encodings for the always-on register-vector write sequencer and its arbiter.
package sirv_aon_regvec_ctrl_pkg;

   typedef enum logic [1:0] {StIdle, StWr, StChk, StRsp} state_e;

   localparam logic REQ_BUS = 1'b0;
   localparam logic REQ_PMU = 1'b1;

   localparam logic [19:0] DEFAULT_KEY = 20'h51F15;

endpackage

// File: rtl/sirv_aon_rr_arb2.sv
// Two-way round-robin arbiter: on a tie, grant the requester not served last.
module sirv_aon_rr_arb2
   import sirv_aon_regvec_ctrl_pkg::*;
(
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       en_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   logic last_q, last_d;

   // Bit 0 is the bus, bit 1 is the PMU.
   always_comb begin
      gnt_o = 2'b00;
      if (en_i) begin
         unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (last_q == REQ_PMU) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
         endcase
      end
   end

   always_comb begin
      last_d = last_q;
      if (|gnt_o) last_d = gnt_o[1];
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) last_q <= REQ_PMU;
      else         last_q <= last_d;
   end

endmodule

// File: rtl/sirv_aon_regvec_ctrl.sv
// Write sequencer for the always-on register bank: arbitrates bus/PMU, writes, verifies by
// readback and returns a one-cycle response. Bus writes to protected registers need a key.
module sirv_aon_regvec_ctrl
   import sirv_aon_regvec_ctrl_pkg::*;
#(
   parameter int unsigned     NREG      = 4,
   parameter int unsigned     DW        = 20,
   parameter int unsigned     AW        = 3,
   parameter logic [DW-1:0]   KEY       = DW'(DEFAULT_KEY),
   parameter logic [NREG-1:0] PROT_MASK = NREG'(4'b0011)
) (
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic               bus_req_valid_i,
   output logic               bus_req_ready_o,
   input  logic [AW-1:0]      bus_req_addr_i,
   input  logic [DW-1:0]      bus_req_wdata_i,
   output logic               bus_rsp_valid_o,
   output logic               bus_rsp_err_o,
   input  logic               pmu_req_valid_i,
   output logic               pmu_req_ready_o,
   input  logic [AW-1:0]      pmu_req_addr_i,
   input  logic [DW-1:0]      pmu_req_wdata_i,
   output logic               pmu_rsp_valid_o,
   output logic               pmu_rsp_err_o,
   output logic [NREG-1:0]    rv_en_o,
   output logic [DW-1:0]      rv_d_o,
   input  logic [NREG*DW-1:0] rv_q_i,
   output logic               unlocked_o
);

   localparam int unsigned   IW       = (NREG > 1) ? $clog2(NREG) : 1;
   localparam logic [AW-1:0] KEY_ADDR = AW'(NREG);

   state_e          state_q, state_d;
   logic            id_q, id_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   data_q, data_d;
   logic            err_q, err_d;
   logic            unlocked_q, unlocked_d;

   logic [1:0]      gnt;
   logic            sel_pmu;
   logic [AW-1:0]   req_addr;
   logic [DW-1:0]   req_data;
   logic [DW-1:0]   rv_q_arr [NREG];

   for (genvar i = 0; i < NREG; i++) begin : g_unpack
      assign rv_q_arr[i] = rv_q_i[i*DW +: DW];
   end

   sirv_aon_rr_arb2 u_arb (
      .clk_i   (clock_i),
      .reset_i (reset_i),
      .en_i    (state_q == StIdle),
      .req_i   ({pmu_req_valid_i, bus_req_valid_i}),
      .gnt_o   (gnt)
   );

   assign sel_pmu  = gnt[1];
   assign req_addr = sel_pmu ? pmu_req_addr_i : bus_req_addr_i;
   assign req_data = sel_pmu ? pmu_req_wdata_i : bus_req_wdata_i;

   always_comb begin
      state_d    = state_q;
      id_d       = id_q;
      addr_d     = addr_q;
      data_d     = data_q;
      err_d      = err_q;
      unlocked_d = unlocked_q;
      unique case (state_q)
         StIdle: begin
            if (|gnt) begin
               id_d    = sel_pmu ? REQ_PMU : REQ_BUS;
               addr_d  = req_addr;
               data_d  = req_data;
               err_d   = 1'b0;
               state_d = StRsp;
               // Any accepted bus request spends the key unless it is itself a correct key.
               if (!sel_pmu) unlocked_d = (req_addr == KEY_ADDR) && (req_data == KEY);
               if (req_addr > KEY_ADDR) begin
                  err_d = 1'b1;
               end else if (req_addr == KEY_ADDR) begin
                  err_d = sel_pmu || (req_data != KEY);
               end else if (!sel_pmu && PROT_MASK[req_addr[IW-1:0]] && !unlocked_q) begin
                  err_d = 1'b1;
               end else begin
                  state_d = StWr;
               end
            end
         end
         StWr:    state_d = StChk;
         StChk: begin
            err_d   = (rv_q_arr[addr_q[IW-1:0]] != data_q);
            state_d = StRsp;
         end
         StRsp:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q    <= StIdle;
         id_q       <= REQ_BUS;
         addr_q     <= '0;
         data_q     <= '0;
         err_q      <= 1'b0;
         unlocked_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         id_q       <= id_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         err_q      <= err_d;
         unlocked_q <= unlocked_d;
      end
   end

   // Enable and response are suppressed while reset is held so an aborted op leaves no trace.
   always_comb begin
      rv_en_o = '0;
      if (state_q == StWr && !reset_i) rv_en_o[addr_q[IW-1:0]] = 1'b1;
   end

   assign rv_d_o          = data_q;
   assign unlocked_o      = unlocked_q;
   assign bus_req_ready_o = (state_q == StIdle);
   assign pmu_req_ready_o = (state_q == StIdle);
   assign bus_rsp_valid_o = (state_q == StRsp) && (id_q == REQ_BUS) && !reset_i;
   assign pmu_rsp_valid_o = (state_q == StRsp) && (id_q == REQ_PMU) && !reset_i;
   assign bus_rsp_err_o   = bus_rsp_valid_o && err_q;
   assign pmu_rsp_err_o   = pmu_rsp_valid_o && err_q;

endmodule

// File: tb/tb_sirv_aon_regvec_ctrl.sv
// Directed bench for the register-vector write sequencer with a behavioural register bank.
module tb_sirv_aon_regvec_ctrl;

   localparam int NREG = 4;
   localparam int DW   = 20;
   localparam int AW   = 3;

   logic               clk = 1'b0;
   logic               reset;
   logic               bus_req_valid, bus_req_ready, bus_rsp_valid, bus_rsp_err;
   logic [AW-1:0]      bus_req_addr;
   logic [DW-1:0]      bus_req_wdata;
   logic               pmu_req_valid, pmu_req_ready, pmu_rsp_valid, pmu_rsp_err;
   logic [AW-1:0]      pmu_req_addr;
   logic [DW-1:0]      pmu_req_wdata;
   logic [NREG-1:0]    rv_en;
   logic [DW-1:0]      rv_d;
   logic [NREG*DW-1:0] rv_q;
   logic               unlocked;

   logic               corrupt;
   logic [DW-1:0]      bank [NREG];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sirv_aon_regvec_ctrl dut (
      .clock_i         (clk),
      .reset_i         (reset),
      .bus_req_valid_i (bus_req_valid),
      .bus_req_ready_o (bus_req_ready),
      .bus_req_addr_i  (bus_req_addr),
      .bus_req_wdata_i (bus_req_wdata),
      .bus_rsp_valid_o (bus_rsp_valid),
      .bus_rsp_err_o   (bus_rsp_err),
      .pmu_req_valid_i (pmu_req_valid),
      .pmu_req_ready_o (pmu_req_ready),
      .pmu_req_addr_i  (pmu_req_addr),
      .pmu_req_wdata_i (pmu_req_wdata),
      .pmu_rsp_valid_o (pmu_rsp_valid),
      .pmu_rsp_err_o   (pmu_rsp_err),
      .rv_en_o         (rv_en),
      .rv_d_o          (rv_d),
      .rv_q_i          (rv_q),
      .unlocked_o      (unlocked)
   );

   // Retention register bank; corrupt flips bit 0 of the stored value to force a readback miss.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NREG; i++) begin
         if (rv_en[i]) bank[i] <= rv_d ^ (corrupt ? 20'h00001 : 20'h00000);
      end
   end
   assign rv_q = {bank[3], bank[2], bank[1], bank[0]};

   typedef struct {
      logic          pmu;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          corrupt;
      int            lat;
      logic          err;
      logic [3:0]    en;
      logic          unl;
   } vec_t;

   vec_t vecs [15];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic run_txn(input int idx, input vec_t v);
      int            lat = 0;
      int            rdy_k = 0;
      logic          err = 1'b0;
      logic [3:0]    en_seen = 4'b0;
      logic [DW-1:0] d_seen = '0;
      logic          other = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_ready_before", idx), {31'b0, bus_req_ready & pmu_req_ready}, 32'd1);
      corrupt = v.corrupt;
      if (v.pmu) begin
         pmu_req_valid = 1'b1; pmu_req_addr = v.addr; pmu_req_wdata = v.data;
      end else begin
         bus_req_valid = 1'b1; bus_req_addr = v.addr; bus_req_wdata = v.data;
      end
      @(posedge clk);
      #1;
      bus_req_valid = 1'b0;
      pmu_req_valid = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (rv_en != 4'b0) begin
            en_seen = en_seen | rv_en;
            d_seen  = rv_d;
         end
         if ((v.pmu ? pmu_rsp_valid : bus_rsp_valid) && lat == 0) begin
            lat = k;
            err = v.pmu ? pmu_rsp_err : bus_rsp_err;
         end
         if (v.pmu ? bus_rsp_valid : pmu_rsp_valid) other = 1'b1;
         if (bus_req_ready && rdy_k == 0) rdy_k = k;
      end
      corrupt = 1'b0;
      check($sformatf("v%0d_rsp_latency", idx), lat, v.lat);
      check($sformatf("v%0d_rsp_err", idx), {31'b0, err}, {31'b0, v.err});
      check($sformatf("v%0d_rv_en", idx), {28'b0, en_seen}, {28'b0, v.en});
      check($sformatf("v%0d_other_rsp", idx), {31'b0, other}, 32'd0);
      check($sformatf("v%0d_ready_again", idx), rdy_k, v.lat + 1);
      check($sformatf("v%0d_unlocked", idx), {31'b0, unlocked}, {31'b0, v.unl});
      if (v.en != 4'b0) check($sformatf("v%0d_rv_d", idx), {12'b0, d_seen}, {12'b0, v.data});
   endtask

   // Both requesters raise valid together; the first enable seen tells who won the tie.
   task automatic tie_pair(input string nm, input logic [3:0] exp_first);
      logic [3:0] order [2];
      int         n = 0;
      order[0] = 4'b0;
      order[1] = 4'b0;
      @(negedge clk);
      bus_req_valid = 1'b1; bus_req_addr = 3'd2; bus_req_wdata = 20'h2A2A2;
      pmu_req_valid = 1'b1; pmu_req_addr = 3'd3; pmu_req_wdata = 20'h3B3B3;
      for (int c = 0; c < 30 && n < 2; c++) begin
         @(negedge clk);
         if (rv_en != 4'b0) begin
            order[n] = rv_en;
            n++;
            if (rv_en == 4'b0100) bus_req_valid = 1'b0;
            if (rv_en == 4'b1000) pmu_req_valid = 1'b0;
         end
      end
      bus_req_valid = 1'b0;
      pmu_req_valid = 1'b0;
      check({nm, "_grants"}, n, 2);
      check({nm, "_first"}, {28'b0, order[0]}, {28'b0, exp_first});
      check({nm, "_second"}, {28'b0, order[1]},
            {28'b0, (exp_first == 4'b0100) ? 4'b1000 : 4'b0100});
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic saw_rsp;
      vecs[0]  = '{1'b0, 3'd4, 20'h51F15, 1'b0, 1, 1'b0, 4'b0000, 1'b1};
      vecs[1]  = '{1'b0, 3'd0, 20'hABCDE, 1'b0, 3, 1'b0, 4'b0001, 1'b0};
      vecs[2]  = '{1'b0, 3'd1, 20'h11111, 1'b0, 1, 1'b1, 4'b0000, 1'b0};
      vecs[3]  = '{1'b0, 3'd4, 20'h12345, 1'b0, 1, 1'b1, 4'b0000, 1'b0};
      vecs[4]  = '{1'b1, 3'd0, 20'h0F0F0, 1'b0, 3, 1'b0, 4'b0001, 1'b0};
      vecs[5]  = '{1'b0, 3'd4, 20'h51F15, 1'b0, 1, 1'b0, 4'b0000, 1'b1};
      vecs[6]  = '{1'b1, 3'd4, 20'h51F15, 1'b0, 1, 1'b1, 4'b0000, 1'b1};
      vecs[7]  = '{1'b1, 3'd5, 20'h00005, 1'b0, 1, 1'b1, 4'b0000, 1'b1};
      vecs[8]  = '{1'b0, 3'd3, 20'h33333, 1'b0, 3, 1'b0, 4'b1000, 1'b0};
      vecs[9]  = '{1'b0, 3'd5, 20'h00005, 1'b0, 1, 1'b1, 4'b0000, 1'b0};
      vecs[10] = '{1'b0, 3'd4, 20'h51F15, 1'b0, 1, 1'b0, 4'b0000, 1'b1};
      vecs[11] = '{1'b0, 3'd2, 20'h24680, 1'b1, 3, 1'b1, 4'b0100, 1'b0};
      vecs[12] = '{1'b1, 3'd1, 20'h13579, 1'b1, 3, 1'b1, 4'b0010, 1'b0};
      vecs[13] = '{1'b0, 3'd4, 20'h51F15, 1'b0, 1, 1'b0, 4'b0000, 1'b1};
      vecs[14] = '{1'b0, 3'd1, 20'h22222, 1'b0, 3, 1'b0, 4'b0010, 1'b0};

      reset = 1'b1;
      corrupt = 1'b0;
      bus_req_valid = 1'b0; bus_req_addr = '0; bus_req_wdata = '0;
      pmu_req_valid = 1'b0; pmu_req_addr = '0; pmu_req_wdata = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_ready", {30'b0, bus_req_ready, pmu_req_ready}, 32'd3);
      check("rst_rv_en", {28'b0, rv_en}, 32'd0);
      check("rst_rv_d", {12'b0, rv_d}, 32'd0);
      check("rst_rsp", {28'b0, bus_rsp_valid, bus_rsp_err, pmu_rsp_valid, pmu_rsp_err}, 32'd0);
      check("rst_unlocked", {31'b0, unlocked}, 32'd0);

      tie_pair("tie_after_reset", 4'b0100);

      for (int i = 0; i < 15; i++) run_txn(i, vecs[i]);

      // Last grant went to the bus, so the next tie favours the PMU.
      tie_pair("tie_after_bus", 4'b1000);

      // Reset during WR: aborts silently and drops the armed key.
      run_txn(100, vecs[0]);
      @(negedge clk);
      pmu_req_valid = 1'b1; pmu_req_addr = 3'd1; pmu_req_wdata = 20'h55555;
      @(posedge clk);
      #1;
      pmu_req_valid = 1'b0;
      @(negedge clk);
      check("midrst_in_wr", {28'b0, rv_en}, 32'b0010);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_rv_en", {28'b0, rv_en}, 32'd0);
      check("midrst_rsp", {30'b0, bus_rsp_valid, pmu_rsp_valid}, 32'd0);
      check("midrst_unlocked", {31'b0, unlocked}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("midrst_ready", {30'b0, bus_req_ready, pmu_req_ready}, 32'd3);
      saw_rsp = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (bus_rsp_valid || pmu_rsp_valid || rv_en != 4'b0) saw_rsp = 1'b1;
      end
      check("midrst_no_late_rsp", {31'b0, saw_rsp}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sirv_aon_regvec_ctrl.md
# sirv_aon_regvec_ctrl

Write sequencer and arbiter for the always-on register bank. The bank is built from `sirv_AsyncResetRegVec`-style retention registers, each `DW` bits wide with a shared `io_en`/`io_d` style write port. Two requesters share the single write path: the peripheral bus (key-protected for selected registers) and the PMU sequencer (trusted). The block grants one request at a time and drives a one-cycle enable into the target register. It then read-back-checks the stored value and returns a one-cycle response to the requester.

## Interface
- `NREG`, 4: number of register vectors in the bank.
- `DW`, 20: register width.
- `AW`, 3: request address width; index `NREG` is the key address.
- `KEY`, 20'h51F15: unlock key value.
- `PROT_MASK`, 4'b0011: bit i=1 means register i needs a key for bus writes.
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `bus_req_valid` in 1, `bus_req_ready` out 1, `bus_req_addr` in AW, `bus_req_wdata` in DW: bus write request.
- `bus_rsp_valid` out 1, `bus_rsp_err` out 1: bus response pulse.
- `pmu_req_valid` in 1, `pmu_req_ready` out 1, `pmu_req_addr` in AW, `pmu_req_wdata` in DW: PMU write request.
- `pmu_rsp_valid` out 1, `pmu_rsp_err` out 1: PMU response pulse.
- `rv_en` out NREG: one-hot write enable, bit i to register vector i `io_en`.
- `rv_d` out DW: write data, fanned out to every `io_d`.
- `rv_q` in NREG*DW: concatenated `io_q` readback; register i occupies `[i*DW +: DW]`.
- `unlocked` out 1: key currently armed.

## Operation
- FSM states: IDLE, WR, CHK, RSP. Both `*_req_ready` are high only in IDLE.
- **IDLE arbitration.**
  - One valid requester: grant it.
  - Both valid: grant the requester not granted last.
  - The last-grant flag resets to PMU, so the first tie goes to the bus.
  - On grant, capture requester id, address and data.
- **Classification at grant.** Flag reflects state before this request.
  - addr > NREG: err=1, go to RSP, no enable.
  - Bus, addr == NREG (key write): unlocked := (wdata == KEY); err = (wdata != KEY); go to RSP.
  - PMU, addr == NREG: err=1; key unaffected.
  - Bus write to register i with PROT_MASK[i]=1 and unlocked=0: err=1, go to RSP, no enable.
  - Otherwise go to WR.
- **Key consumption.** Every accepted bus request other than a correct key write clears `unlocked`; this includes rejected and unprotected writes. PMU requests never change `unlocked`.
- **WR:** `rv_en[addr]`=1 and `rv_d`=captured data for exactly this cycle. Go to CHK.
- **CHK:** err = (`rv_q` slice[addr] != captured data). Go to RSP.
- **RSP:** assert `rsp_valid` of the granted requester for one cycle with its err. Go to IDLE.
- Unused outputs: `rv_en`=0 outside WR; `rv_d` holds the last captured data; the non-granted requester's rsp is 0.
- **Reset values:** state IDLE, `rv_en`=0, `rv_d`=0, all rsp_valid/err=0, `unlocked`=0, last-grant=PMU.
- **Reset mid-operation:** abort the operation, emit no response, and drop any pending enable.

## Timing
- Accept at edge T0, where valid&ready are sampled high.
- WR in cycle T0+1 (`rv_en` high); CHK in T0+2; response in T0+3.
- `*_ready` returns high in T0+4, giving one register write per 4 cycles.
- Error or key path: IDLE→RSP directly, response in T0+1, ready again in T0+2.
- `rv_q` reflects the write at CHK because the register samples `io_en` at the WR→CHK edge.
- Requesters must hold valid/addr/data until accepted. Nothing is buffered beyond the one captured request.
- All outputs are registered or decoded from state only; there is no combinational path from req to rsp.

## Structure
- Shared package/include holds: FSM state encoding, the requester-id constants (BUS=0, PMU=1), and the default KEY.
- One natural sub-module, `sirv_aon_rr_arb2`: 2-way round-robin arbiter with registered last-grant flag and a one-hot grant output. The FSM and the key logic stay in the top module.

## Test plan
- **Bus protected write:**
  - Bus key 20'h51F15 → rsp at T0+1, err=0, `unlocked`=1.
  - Then bus write addr 0 data 20'hABCDE → `rv_en`=4'b0001 in T0+1, rsp err=0 at T0+3, `unlocked`=0 afterwards.
- **Locked write:** bus write addr 1 without key → no `rv_en` pulse, `bus_rsp_err`=1 at T0+1. Wrong key 20'h12345 → err=1, `unlocked`=0.
- **Simultaneous:** both valid after reset → bus granted first and PMU next; repeated ties alternate. PMU write to protected addr 0 succeeds without a key.
- **Readback mismatch:** model forces `rv_q` slice ≠ data during CHK → rsp err=1.
- **Bad address and unprotected write:**
  - Address 5 from either requester → err=1, no enable.
  - Unprotected bus write (addr 3) with `unlocked`=1 → write succeeds and clears `unlocked`.
- **Reset mid-operation:** `reset` asserted during WR → next cycle IDLE, `rv_en`=0, no rsp pulse, `unlocked`=0, both ready=1 after reset deasserts.
